simon_decrypt_core: RTL and testbench

Iterative SIMON decryption engine: accepts a 2n-bit ciphertext block and applies one inverse Feistel round per clock, using round keys from an internal key file loaded by a write port. It returns the plaintext on a valid/ready output handshake. It is the decrypt-side counterpart of the encryption datapath built on the left circular shifts S1, S2 and S8. It reuses the same round function f(x) = (S1(x) & S8(x)) ^ S2(x). It sits between the key-schedule unit, which writes the key file, and the block-level I/O wrapper.

---
 rtl/simon_decrypt_core.sv | 127 ++++++++++++
 tb/tb_simon_decrypt_core.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/simon_decrypt_core.sv
// simon_decrypt_core: iterative SIMON decryption, one inverse Feistel round per clock.
// Latency: ROUNDS cycles from input accept to out_valid; one block per ROUNDS+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, no same-edge re-accept.
//
// Ports:
//   clk, rst_n             clock, async active-low reset (key file is not reset)
//   key_we/addr/data       round-key write port, honoured only while IDLE
//   in_valid/in_ready      ciphertext handshake, ct_in = {x, y}
//   out_valid/out_ready    plaintext handshake, pt_out = {x, y}
module simon_decrypt_core #(
  parameter int N      = 16,
  parameter int ROUNDS = 32,
  parameter int AW     = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            key_we,
  input  logic [AW-1:0]   key_addr,
  input  logic [N-1:0]    key_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*N-1:0]  ct_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*N-1:0]  pt_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      x_q, x_d;
  logic [N-1:0]      y_q, y_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [2*N-1:0]    pt_q, pt_d;
  logic              out_valid_q, out_valid_d;
  logic [N-1:0]      key_q [ROUNDS];
  logic [N-1:0]      round_key;

  function automatic logic [N-1:0] rotl(input logic [N-1:0] v, input int s);
    return (v << s) | (v >> (N - s));
  endfunction

  function automatic logic [N-1:0] simon_f(input logic [N-1:0] v);
    return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
  endfunction

  // Key file: plain registers, no reset. Addresses >= ROUNDS never match an
  // entry, so such writes fall through without effect.
  always_ff @(posedge clk) begin
    for (int r = 0; r < ROUNDS; r++) begin
      if (key_we && (state_q == IDLE) && (key_addr == AW'(r))) begin
        key_q[r] <= key_data;
      end
    end
  end

  // Combinational read of the key for the round being computed this cycle.
  always_comb begin
    round_key = '0;
    for (int r = 0; r < ROUNDS; r++) begin
      if (cnt_q == AW'(r)) begin
        round_key = key_q[r];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      cnt_q       <= '0;
      pt_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cnt_q       <= cnt_d;
      pt_q        <= pt_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    cnt_d       = cnt_q;
    pt_d        = pt_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = ct_in[2*N-1:N];
          y_d     = ct_in[N-1:0];
          cnt_d   = AW'(ROUNDS - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        // Inverse round: undo x' = y ^ f(x) ^ k, y' = x.
        x_d = y_q;
        y_d = x_q ^ simon_f(y_q) ^ round_key;
        if (cnt_q == '0) begin
          pt_d        = {x_d, y_d};
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - AW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign pt_out    = pt_q;

endmodule

// File: tb/tb_simon_decrypt_core.sv
module tb_simon_decrypt_core;

  localparam logic [31:0] PUB_CT = 32'hC69BE9BB;
  localparam logic [31:0] PUB_PT = 32'h65656877;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: SIMON32/64 geometry.
  logic        rst_n, key_we, in_valid, in_ready, out_valid, out_ready;
  logic [4:0]  key_addr;
  logic [15:0] key_data;
  logic [31:0] ct_in, pt_out;

  // Single-round instance.
  logic        s_key_we, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [0:0]  s_key_addr;
  logic [15:0] s_key_data;
  logic [31:0] s_ct_in, s_pt_out;

  simon_decrypt_core #(.N(16), .ROUNDS(32), .AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .key_we(key_we), .key_addr(key_addr), .key_data(key_data),
    .in_valid(in_valid), .in_ready(in_ready), .ct_in(ct_in),
    .out_valid(out_valid), .out_ready(out_ready), .pt_out(pt_out)
  );

  simon_decrypt_core #(.N(16), .ROUNDS(1), .AW(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .key_we(s_key_we), .key_addr(s_key_addr), .key_data(s_key_data),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .ct_in(s_ct_in),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .pt_out(s_pt_out)
  );

  int n_assert = 0;
  int n_fail   = 0;
  logic [15:0] rk [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ror(input logic [15:0] v, input int s);
    return (v >> s) | (v << (16 - s));
  endfunction

  // SIMON32/64 key expansion (m = 4, sequence z0).
  task automatic build_pub_keys();
    logic [61:0] z0;
    logic [15:0] tmp;
    z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    rk[0] = 16'h0100; rk[1] = 16'h0908; rk[2] = 16'h1110; rk[3] = 16'h1918;
    for (int i = 4; i < 32; i++) begin
      tmp   = ror(rk[i-1], 3) ^ rk[i-3];
      tmp   = tmp ^ ror(tmp, 1);
      rk[i] = ~rk[i-4] ^ tmp ^ {15'b0, z0[61-(i-4)]} ^ 16'h0003;
    end
  endtask

  task automatic wr_key(input logic [4:0] a, input logic [15:0] d);
    @(negedge clk);
    key_we = 1'b1; key_addr = a; key_data = d;
    @(posedge clk); #1;
    key_we = 1'b0;
  endtask

  // Accept one block, then count edges until out_valid. Optionally issue a key
  // write in the middle of RUN.
  task automatic run_main(input logic [31:0] ct, input bit inject, output int lat);
    @(negedge clk);
    in_valid = 1'b1; ct_in = ct;
    @(posedge clk); #1;
    in_valid = 1'b0; ct_in = $urandom;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (inject && lat == 3) begin
        key_we = 1'b1; key_addr = 5'd5; key_data = 16'hDEAD;
      end else begin
        key_we = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    key_we = 1'b0;
  endtask

  initial begin
    #100000;
    $error("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;

    // Reset with random inputs on both instances.
    rst_n = 1'b0;
    out_ready = 1'b1; s_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      key_we = $urandom; key_addr = $urandom; key_data = $urandom;
      in_valid = $urandom; ct_in = $urandom;
      s_key_we = $urandom; s_key_addr = $urandom; s_key_data = $urandom;
      s_in_valid = $urandom; s_ct_in = $urandom;
    end
    @(posedge clk); #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_pt_out", pt_out, 32'd0);
    check("rst_s_in_ready", {31'b0, s_in_ready}, 32'd1);
    check("rst_s_out_valid", {31'b0, s_out_valid}, 32'd0);
    check("rst_s_pt_out", s_pt_out, 32'd0);
    @(negedge clk);
    key_we = 1'b0; in_valid = 1'b0; s_key_we = 1'b0; s_in_valid = 1'b0;
    rst_n = 1'b1;

    // All-zero keys, zero block.
    for (int i = 0; i < 32; i++) wr_key(5'(i), 16'h0000);
    run_main(32'h0, 1'b0, lat);
    check("zero_latency", 32'(lat), 32'd32);
    check("zero_pt", pt_out, 32'h0);
    check("zero_in_ready_done", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check("zero_out_valid_after_hs", {31'b0, out_valid}, 32'd0);
    check("zero_in_ready_after_hs", {31'b0, in_ready}, 32'd1);

    // Single-round arithmetic; write to address 1 (>= ROUNDS) must be dropped.
    @(negedge clk);
    s_key_we = 1'b1; s_key_addr = 1'b0; s_key_data = 16'h0000;
    @(negedge clk);
    s_key_addr = 1'b1; s_key_data = 16'hFFFF;
    @(negedge clk);
    s_key_we = 1'b0;
    s_in_valid = 1'b1; s_ct_in = 32'h00000001;
    @(posedge clk); #1;
    s_in_valid = 1'b0; s_ct_in = 32'hFFFFFFFF;
    lat = 0;
    while (s_out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    check("one_round_latency", 32'(lat), 32'd1);
    check("one_round_pt", s_pt_out, 32'h00010004);
    @(posedge clk); #1;
    check("one_round_in_ready_after_hs", {31'b0, s_in_ready}, 32'd1);

    // Published vector.
    build_pub_keys();
    for (int i = 0; i < 32; i++) wr_key(5'(i), rk[i]);
    run_main(PUB_CT, 1'b0, lat);
    check("pub_latency", 32'(lat), 32'd32);
    check("pub_pt", pt_out, PUB_PT);
    @(posedge clk); #1;
    check("pub_out_valid_after_hs", {31'b0, out_valid}, 32'd0);
    check("pub_pt_kept", pt_out, PUB_PT);

    // Backpressure in DONE, key write in RUN ignored, in_valid ignored in DONE.
    out_ready = 1'b0;
    run_main(PUB_CT, 1'b1, lat);
    check("bp_latency", 32'(lat), 32'd32);
    check("bp_pt", pt_out, PUB_PT);
    in_valid = 1'b1; ct_in = 32'h12345678;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_pt_stable", pt_out, PUB_PT);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("hs_out_valid", {31'b0, out_valid}, 32'd0);
    check("hs_no_back_to_back", {31'b0, in_ready}, 32'd1);
    run_main(PUB_CT, 1'b0, lat);
    check("after_run_write_latency", 32'(lat), 32'd32);
    check("after_run_write_pt", pt_out, PUB_PT);
    @(posedge clk); #1;

    // Reset in the middle of RUN.
    @(negedge clk);
    in_valid = 1'b1; ct_in = PUB_CT;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (16) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_pt_out", pt_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_main(PUB_CT, 1'b0, lat);
    check("post_rst_latency", 32'(lat), 32'd32);
    check("post_rst_pt", pt_out, PUB_PT);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
